// File: rtl/hough_pkg.sv
// Shared types and widths for the Hough line overlay.
package hough_pkg;

  localparam int unsigned WIDTH_DEF    = 720;
  localparam int unsigned HEIGHT_DEF   = 540;
  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned FRAC_BITS    = 13;
  localparam int unsigned RADIUS_WIDTH = 16;
  localparam int unsigned ACC_W        = DATA_WIDTH + RADIUS_WIDTH + 2;
  localparam int unsigned X_W          = $clog2(WIDTH_DEF);
  localparam int unsigned Y_W          = $clog2(HEIGHT_DEF);

  typedef logic signed [DATA_WIDTH-1:0] trig_t;
  typedef logic signed [ACC_W-1:0]      acc_t;

  typedef struct packed {
    logic  valid;
    trig_t cos;
    trig_t sin;
    acc_t  rho_q;
  } line_slot_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Per-channel average: 9-bit sum, drop the LSB.
  function automatic rgb_t avg_rgb(input rgb_t a, input rgb_t b);
    logic [8:0] sr, sg, sb;
    rgb_t       o;
    sr = {1'b0, a.r} + {1'b0, b.r};
    sg = {1'b0, a.g} + {1'b0, b.g};
    sb = {1'b0, a.b} + {1'b0, b.b};
    o.r = sr[8:1];
    o.g = sg[8:1];
    o.b = sb[8:1];
    return o;
  endfunction

endpackage

// File: rtl/hough_line_slot.sv
// One line slot: incremental distance accumulators and round-to-nearest hit test.
module hough_line_slot
  import hough_pkg::*;
#(
  parameter int unsigned THICKNESS = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  line_slot_t slot,
  input  logic       first,
  input  logic       pop,
  input  logic       x_wrap,
  output logic       hit
);

  localparam longint HALF = longint'(1) <<< (FRAC_BITS - 1);
  localparam longint TH   = longint'(THICKNESS) <<< FRAC_BITS;
  localparam acc_t   LO   = acc_t'(-TH - HALF);
  localparam acc_t   HI   = acc_t'(TH + HALF);

  acc_t row_acc_q, row_acc_d;
  acc_t pix_acc_q, pix_acc_d;
  acc_t base_row, base_pix, cos_x, sin_x;

  // Distance for the pixel being popped and the accumulator advance.
  // On the (0,0) pop both accumulators restart from -rho of the newly copied slot.
  always_comb begin
    cos_x     = acc_t'(slot.cos);
    sin_x     = acc_t'(slot.sin);
    base_row  = first ? -slot.rho_q : row_acc_q;
    base_pix  = first ? -slot.rho_q : pix_acc_q;
    row_acc_d = row_acc_q;
    pix_acc_d = pix_acc_q;
    if (pop) begin
      if (x_wrap) begin
        row_acc_d = base_row + sin_x;
        pix_acc_d = base_row + sin_x;
      end else begin
        row_acc_d = base_row;
        pix_acc_d = base_pix + cos_x;
      end
    end
    hit = slot.valid && (base_pix >= LO) && (base_pix < HI);
  end

  // Accumulator registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_acc_q <= '0;
      pix_acc_q <= '0;
    end else begin
      row_acc_q <= row_acc_d;
      pix_acc_q <= pix_acc_d;
    end
  end

endmodule

// File: rtl/lookup_table.sv
// Combinational sin/cos ROM, 1 degree per step, Q(FRAC_BITS) signed.
// Table contents are computed at elaboration from an integer Taylor series.
module lookup_table
  import hough_pkg::*;
#(
  parameter int unsigned ANGLE_RANGE = 180
) (
  input  logic [$clog2(ANGLE_RANGE)-1:0] angle,
  output trig_t                          cos_val,
  output trig_t                          sin_val
);

  // sin(deg) for deg in 0..90; radians held in Q30, pi/180 = 18740330 / 2^30.
  function automatic trig_t sin_q(input int unsigned deg);
    longint x, x2, term, sum;
    x    = longint'(deg) * 64'sd18740330;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int unsigned k = 1; k <= 6; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return trig_t'((sum + 64'sd65536) >>> (30 - FRAC_BITS));
  endfunction

  function automatic trig_t sin_deg(input int unsigned d);
    if (d <= 90)      return sin_q(d);
    else if (d < 180) return sin_q(180 - d);
    else              return '0;
  endfunction

  function automatic trig_t cos_deg(input int unsigned d);
    if (d <= 90)      return sin_q(90 - d);
    else if (d < 180) return -sin_q(d - 90);
    else              return '0;
  endfunction

  trig_t cos_rom [ANGLE_RANGE];
  trig_t sin_rom [ANGLE_RANGE];

  for (genvar a = 0; a < ANGLE_RANGE; a++) begin : g_rom
    localparam trig_t COS_A = cos_deg(a);
    localparam trig_t SIN_A = sin_deg(a);
    assign cos_rom[a] = COS_A;
    assign sin_rom[a] = SIN_A;
  end

  // Table read; out-of-range indices read as zero.
  always_comb begin
    cos_val = '0;
    sin_val = '0;
    if (32'(angle) < ANGLE_RANGE) begin
      cos_val = cos_rom[angle];
      sin_val = sin_rom[angle];
    end
  end

endmodule

// File: rtl/hough_line_overlay.sv
// Streaming Hough line overlay: recolours pixels lying on up to NUM_LINES lines.
// Optional macro HOUGH_OVERLAY_BLEND_EN: hit pixels are averaged with LINE_COLOR
// instead of being replaced by it.
module hough_line_overlay
  import hough_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned HEIGHT      = HEIGHT_DEF,
  parameter int unsigned ANGLE_RANGE = 180,
  parameter int unsigned NUM_LINES   = 4,
  parameter int unsigned THICKNESS   = 0,
  parameter logic [23:0] LINE_COLOR  = 24'h00FF00
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_empty,
  output logic                                in_rd_en,
  input  logic [23:0]                         in_dout,
  input  logic                                out_full,
  output logic                                out_wr_en,
  output logic [23:0]                         out_din,
  input  logic                                line_wr_en,
  input  logic [$clog2(NUM_LINES)-1:0]        line_idx,
  input  logic                                line_valid,
  input  logic [$clog2(ANGLE_RANGE)-1:0]      line_angle,
  input  logic signed [RADIUS_WIDTH-1:0]      line_radius,
  output logic                                frame_done
);

  localparam int unsigned CX_W = (WIDTH == WIDTH_DEF) ? X_W : $clog2(WIDTH);
  localparam int unsigned CY_W = (HEIGHT == HEIGHT_DEF) ? Y_W : $clog2(HEIGHT);

  line_slot_t shadow_q [NUM_LINES];
  line_slot_t shadow_d [NUM_LINES];
  line_slot_t active_q [NUM_LINES];
  line_slot_t active_d [NUM_LINES];

  logic [CX_W-1:0] x_q, x_d;
  logic [CY_W-1:0] y_q, y_d;
  logic            valid_q, valid_d;
  logic [23:0]     pix_q, pix_d;
  logic            last_q, last_d;

  logic                 pop, first_pop, x_last, y_last, any_hit;
  logic [NUM_LINES-1:0] hit_vec;
  logic [23:0]          hit_color;
  trig_t                lut_cos, lut_sin;

  lookup_table #(
    .ANGLE_RANGE(ANGLE_RANGE)
  ) u_lut (
    .angle  (line_angle),
    .cos_val(lut_cos),
    .sin_val(lut_sin)
  );

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_slot
    hough_line_slot #(
      .THICKNESS(THICKNESS)
    ) u_slot (
      .clock (clock),
      .reset (reset),
      .slot  (active_d[i]),
      .first (first_pop),
      .pop   (pop),
      .x_wrap(x_last),
      .hit   (hit_vec[i])
    );
  end

  // Handshake, line tables, counters and stage next-state.
  // The active table is loaded from the pre-write shadow, so a write landing on
  // the (0,0) pop waits for the following frame.
  always_comb begin
    in_rd_en  = !reset && !in_empty && (!valid_q || !out_full);
    out_wr_en = valid_q && !out_full;
    pop       = in_rd_en;
    x_last    = (x_q == CX_W'(WIDTH - 1));
    y_last    = (y_q == CY_W'(HEIGHT - 1));
    first_pop = pop && (x_q == '0) && (y_q == '0);

    shadow_d = shadow_q;
    if (line_wr_en) begin
      shadow_d[line_idx].valid = line_valid;
      shadow_d[line_idx].cos   = lut_cos;
      shadow_d[line_idx].sin   = lut_sin;
      shadow_d[line_idx].rho_q = acc_t'(line_radius) <<< FRAC_BITS;
    end
    active_d = first_pop ? shadow_q : active_q;

    any_hit = |hit_vec;
`ifdef HOUGH_OVERLAY_BLEND_EN
    hit_color = avg_rgb(rgb_t'(in_dout), rgb_t'(LINE_COLOR));
`else
    hit_color = LINE_COLOR;
`endif

    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    pix_d   = pix_q;
    last_d  = last_q;
    if (pop) begin
      x_d     = x_last ? '0 : x_q + CX_W'(1);
      if (x_last) y_d = y_last ? '0 : y_q + CY_W'(1);
      valid_d = 1'b1;
      pix_d   = any_hit ? hit_color : in_dout;
      last_d  = x_last && y_last;
    end else if (out_wr_en) begin
      valid_d = 1'b0;
    end

    out_din    = pix_q;
    frame_done = out_wr_en && last_q;
  end

  // State registers; reset discards staged data and invalidates all slots.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      x_q      <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      pix_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      pix_q    <= pix_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_hough_line_overlay.sv
// Directed bench for hough_line_overlay on an 8x4 frame.
module tb_hough_line_overlay;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_empty;
  logic        in_rd_en;
  logic [23:0] in_dout;
  logic        out_full;
  logic        out_wr_en;
  logic [23:0] out_din;
  logic        line_wr_en;
  logic [1:0]  line_idx;
  logic        line_valid;
  logic [7:0]  line_angle;
  logic signed [15:0] line_radius;
  logic        frame_done;

  always #5 clock = ~clock;

  hough_line_overlay #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .THICKNESS(0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .in_dout    (in_dout),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .out_din    (out_din),
    .line_wr_en (line_wr_en),
    .line_idx   (line_idx),
    .line_valid (line_valid),
    .line_angle (line_angle),
    .line_radius(line_radius),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Expected lines for the frame in flight: column exp_vert, row exp_horiz (-1 = none).
  int exp_vert  = -1;
  int exp_horiz = -1;

  // Write applied on the exact cycle pixel (0,0) is popped.
  bit          pend_wr = 1'b0;
  logic [1:0]  pend_idx;
  logic        pend_valid;
  logic [7:0]  pend_ang;
  logic signed [15:0] pend_rad;

  logic [23:0] p3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] src_pix(input int n);
    if (n == 3) return 24'h202020;
    return {8'(n * 7 + 1), 8'(n), 8'h5A};
  endfunction

  function automatic logic [23:0] line_px(input logic [23:0] s);
`ifdef HOUGH_OVERLAY_BLEND_EN
    logic [8:0] r, g, b;
    r = {1'b0, s[23:16]} + 9'h000;
    g = {1'b0, s[15:8]}  + 9'h0FF;
    b = {1'b0, s[7:0]}   + 9'h000;
    return {r[8:1], g[8:1], b[8:1]};
`else
    return 24'h00FF00;
`endif
  endfunction

  function automatic logic [23:0] exp_pix(input int n);
    int x, y;
    x = n % W;
    y = n / W;
    if (x == exp_vert || y == exp_horiz) return line_px(src_pix(n));
    return src_pix(n);
  endfunction

  task automatic write_line(input logic [1:0] idx, input logic v, input logic [7:0] ang,
                            input logic signed [15:0] rad);
    @(posedge clock);
    #1;
    line_idx    = idx;
    line_valid  = v;
    line_angle  = ang;
    line_radius = rad;
    line_wr_en  = 1'b1;
    @(posedge clock);
    #1;
    line_wr_en = 1'b0;
  endtask

  // Streams one frame; abort_after >= 0 stops feeding after that many pops and returns.
  task automatic run_frame(input int stall_pct, input int bubble_pct, input int abort_after);
    int  src_idx = 0, out_idx = 0, fd = 0, cyc = 0;
    int  first_pop = -1, first_push = -1;
    bit  done = 1'b0;
    while (!done) begin
      @(posedge clock);
      #1;
      cyc++;
      if (line_wr_en && pend_wr) begin
        line_wr_en = 1'b0;
        pend_wr    = 1'b0;
      end
      out_full = ($urandom_range(0, 99) < stall_pct);
      if (abort_after >= 0 && src_idx >= abort_after) in_empty = 1'b1;
      else in_empty = (src_idx >= NPIX) || ($urandom_range(0, 99) < bubble_pct);
      in_dout = (src_idx < NPIX) ? src_pix(src_idx) : 24'hDEAD00;
      @(negedge clock);
      if (frame_done) fd++;
      if (out_wr_en) begin
        if (first_push < 0) first_push = cyc;
        check("frame_done", frame_done, (out_idx == NPIX - 1));
        if (out_idx < NPIX) begin
          check($sformatf("pix%0d", out_idx), out_din, exp_pix(out_idx));
          if (out_idx == 3) p3 = out_din;
        end else begin
          check("push_count", out_idx + 1, NPIX);
        end
        out_idx++;
      end
      if (in_rd_en) begin
        if (first_pop < 0) first_pop = cyc;
        if (src_idx == 0 && pend_wr) begin
          line_idx    = pend_idx;
          line_valid  = pend_valid;
          line_angle  = pend_ang;
          line_radius = pend_rad;
          line_wr_en  = 1'b1;
        end
        src_idx++;
      end
      if (abort_after >= 0 && src_idx >= abort_after) done = 1'b1;
      if (abort_after < 0 && out_idx >= NPIX) done = 1'b1;
      if (cyc > 2000) begin
        check("timeout", cyc, 0);
        done = 1'b1;
      end
    end
    if (abort_after < 0) begin
      if (stall_pct == 0 && bubble_pct == 0) check("latency", first_push - first_pop, 1);
      @(posedge clock);
      #1;
      in_empty = 1'b1;
      out_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        if (frame_done) fd++;
        check("no_extra_push", out_wr_en, 0);
      end
      check("done_count", fd, 1);
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_empty    = 1'b0;
    in_dout     = 24'h123456;
    out_full    = 1'b0;
    line_wr_en  = 1'b0;
    line_idx    = '0;
    line_valid  = 1'b0;
    line_angle  = '0;
    line_radius = '0;
    p3          = '0;
    #1;
    check("rst_in_rd_en", in_rd_en, 0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_out_din", out_din, 0);
    check("rst_frame_done", frame_done, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    in_empty = 1'b1;
    reset    = 1'b0;

    // Vertical line at x=3.
    write_line(2'd0, 1'b1, 8'd0, 16'sd3);
    exp_vert = 3; exp_horiz = -1;
    run_frame(0, 0, -1);
`ifdef HOUGH_OVERLAY_BLEND_EN
    check("blend_202020", p3, 24'h108F10);
`endif

    // Horizontal line at y=2.
    write_line(2'd0, 1'b1, 8'd90, 16'sd2);
    exp_vert = -1; exp_horiz = 2;
    run_frame(0, 0, -1);

    // Slot1 disabled, re-enabled mid-frame: only visible from the next frame.
    write_line(2'd0, 1'b1, 8'd0, 16'sd1);
    write_line(2'd1, 1'b0, 8'd90, 16'sd0);
    exp_vert = 1; exp_horiz = -1;
    fork
      run_frame(0, 0, -1);
      begin
        repeat (12) @(posedge clock);
        write_line(2'd1, 1'b1, 8'd90, 16'sd0);
      end
    join

    // Disable slot0 on the (0,0) pop: this frame keeps it, the next loses it.
    pend_idx = 2'd0; pend_valid = 1'b0; pend_ang = 8'd0; pend_rad = 16'sd1;
    pend_wr  = 1'b1;
    exp_vert = 1; exp_horiz = 0;
    run_frame(0, 0, -1);
    exp_vert = -1; exp_horiz = 0;
    run_frame(0, 0, -1);

    // Backpressure and source bubbles.
    write_line(2'd0, 1'b1, 8'd0, 16'sd6);
    exp_vert = 6; exp_horiz = 0;
    run_frame(50, 30, -1);
    run_frame(50, 30, -1);

    // Reset after 13 pops: outputs clear asynchronously, then pure pass-through.
    run_frame(0, 0, 13);
    in_empty = 1'b0;
    out_full = 1'b0;
    #1;
    check("pre_reset_stage", out_wr_en, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_out_wr_en", out_wr_en, 0);
    check("async_out_din", out_din, 0);
    check("async_in_rd_en", in_rd_en, 0);
    check("async_frame_done", frame_done, 0);
    in_empty = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    exp_vert = -1; exp_horiz = -1;
    run_frame(0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
